// File: rtl/poc_fifo.sv
// poc_fifo: parallel printer output controller with a DEPTH-entry transmit FIFO.
// Bus side: SR/BR/LVL register map, registered read data, active-low IRQ.
// Printer side: PD/TR handshake with a fixed-width strobe and RDY timeout.
//
// Printer FSM states
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | no byte in flight; pops FIFO head when data present and RDY=1
//   S_STROBE  | TR high, strobe down-counter running
//   S_WAIT_LO | TR low, waiting for RDY to fall; timeout down-counter running
//   S_WAIT_HI | RDY seen low, waiting for it to return high
module poc_fifo #(
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int STB_CYC = 2,
    parameter int TMO_CYC = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [1:0]    RW,
    input  logic [1:0]    ADDR,
    input  logic [DW-1:0] Din,
    output logic [DW-1:0] Dout,
    output logic          IRQ,
    output logic [DW-1:0] PD,
    output logic          TR,
    input  logic          RDY
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STB_CYC) + 1;
    localparam int TW = $clog2(TMO_CYC) + 1;

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [SW-1:0] STB_LOAD = SW'(STB_CYC - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_CYC - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_STROBE  = 2'd1;
    localparam logic [1:0] S_WAIT_LO = 2'd2;
    localparam logic [1:0] S_WAIT_HI = 2'd3;

    localparam logic [1:0] A_SR  = 2'd0;
    localparam logic [1:0] A_BR  = 2'd1;
    localparam logic [1:0] A_LVL = 2'd2;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [SW-1:0] stb_cnt_q, stb_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tr_q, tr_d;
    logic [DW-1:0] pd_q, pd_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          irq_q, irq_d;
    logic          ie_q, ie_d;
    logic          ovf_q, ovf_d;
    logic          terr_q, terr_d;

    logic          wr_cmd, rd_cmd, sr_wr;
    logic          full, empty;
    logic          pop, push_req, push_ok;
    logic          ovf_set, terr_set;
    logic [DW-1:0] sr_val, rd_val;

    // Bus decode and FIFO push/pop arbitration; a pop frees the slot a full-FIFO push needs
    always_comb begin
        wr_cmd   = (RW == 2'b11);
        rd_cmd   = (RW == 2'b10);
        sr_wr    = wr_cmd && (ADDR == A_SR);
        push_req = wr_cmd && (ADDR == A_BR);
        full     = (cnt_q == FULL_LVL);
        empty    = (cnt_q == '0);
        pop      = (state_q == S_IDLE) && !empty && RDY;
        push_ok  = push_req && (!full || pop);
        ovf_set  = push_req && !push_ok;
    end

    // FIFO storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = Din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Printer handshake FSM with strobe and timeout down-counters
    always_comb begin
        state_d   = state_q;
        stb_cnt_d = stb_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        tr_d      = tr_q;
        pd_d      = pd_q;
        terr_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    pd_d      = mem_q[rd_ptr_q];
                    tr_d      = 1'b1;
                    stb_cnt_d = STB_LOAD;
                    state_d   = S_STROBE;
                end
            end
            S_STROBE: begin
                if (stb_cnt_q == '0) begin
                    tr_d      = 1'b0;
                    tmo_cnt_d = TMO_LOAD;
                    state_d   = S_WAIT_LO;
                end else begin
                    stb_cnt_d = stb_cnt_q - SW'(1);
                end
            end
            S_WAIT_LO: begin
                if (!RDY) begin
                    state_d = S_WAIT_HI;
                end else if (tmo_cnt_q == '0) begin
                    // printer never acknowledged: the byte is dropped and the FIFO moves on
                    terr_set = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TW'(1);
                end
            end
            default: begin
                if (RDY) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Control/status flags and registered interrupt; a set beats a same-cycle clear
    always_comb begin
        ie_d   = sr_wr ? Din[0] : ie_q;
        ovf_d  = ovf_q;
        terr_d = terr_q;
        if (sr_wr && Din[5]) ovf_d = 1'b0;
        if (ovf_set)         ovf_d = 1'b1;
        if (sr_wr && Din[4]) terr_d = 1'b0;
        if (terr_set)        terr_d = 1'b1;
        irq_d = !(ie_q && (!full || terr_q));
    end

    // Register read mux, captured into Dout only on a read command
    always_comb begin
        sr_val    = '0;
        sr_val[7] = !full;
        sr_val[6] = empty && (state_q == S_IDLE);
        sr_val[5] = ovf_q;
        sr_val[4] = terr_q;
        sr_val[0] = ie_q;
        case (ADDR)
            A_SR:    rd_val = sr_val;
            A_LVL:   rd_val = DW'(cnt_q);
            default: rd_val = '0;
        endcase
        dout_d = rd_cmd ? rd_val : dout_q;
    end

    // State registers; reset aborts any transfer and discards FIFO contents
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
            stb_cnt_q <= '0;
            tmo_cnt_q <= '0;
            tr_q      <= 1'b0;
            pd_q      <= '0;
            dout_q    <= '0;
            irq_q     <= 1'b1;
            ie_q      <= 1'b0;
            ovf_q     <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            stb_cnt_q <= stb_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            tr_q      <= tr_d;
            pd_q      <= pd_d;
            dout_q    <= dout_d;
            irq_q     <= irq_d;
            ie_q      <= ie_d;
            ovf_q     <= ovf_d;
            terr_q    <= terr_d;
        end
    end

    assign Dout = dout_q;
    assign IRQ  = irq_q;
    assign PD   = pd_q;
    assign TR   = tr_q;

endmodule

// File: doc/poc_fifo.md
# poc_fifo

Parametrised parallel output controller between the processor bus and a printer-class peripheral. It replaces the single-byte buffer register with a DEPTH-entry transmit FIFO. It provides polled and interrupt modes selectable by software, a programmable-width TR strobe, a RDY-acknowledge timeout, and sticky overflow and timeout error flags. It sits between the Processor bus (RW/ADDR/Din/Dout/IRQ) and the printer (PD/TR/RDY).

## Interface
- DW, 8: data width of Din, Dout and PD; must be at least 8.
- DEPTH, 4: FIFO entries; must be a power of two, at least 2.
- STB_CYC, 2: TR high time in clock cycles; must be at least 1.
- TMO_CYC, 64: maximum cycles to wait for RDY to fall after TR; must be at least 1.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- RW  input  2  bus command: 2'b11 is a write, 2'b10 is a read, any other value is idle.
- ADDR  input  2  register select: 0 = SR, 1 = BR (FIFO push), 2 = LVL, 3 reserved.
- Din  input  DW  write data.
- Dout  output  DW  read data, registered.
- IRQ  output  1  interrupt request, active low.
- PD  output  DW  data to the printer.
- TR  output  1  transfer strobe to the printer.
- RDY  input  1  printer ready; assumed already synchronous to CLK.

## Operation
- Register map, read view (RW = 2'b10):
  - SR: bit 7 = NF (FIFO not full), bit 6 = EMP (FIFO empty and FSM in IDLE), bit 5 = OVF, bit 4 = TERR, bit 0 = IE; all other bits read 0.
  - LVL: zero-extended FIFO occupancy, 0..DEPTH.
  - BR and address 3 read 0.
- Register map, write view (RW = 2'b11):
  - SR: IE is loaded from Din[0]. Writing 1 to Din[5] clears OVF; writing 1 to Din[4] clears TERR.
  - BR: pushes Din into the FIFO.
  - LVL and address 3: writes are ignored.
- FIFO behaviour:
  - Circular buffer with wrap-around pointers and an occupancy counter of width clog2(DEPTH)+1.
  - A push is accepted if occupancy < DEPTH, or if a pop occurs in the same cycle.
  - A push when full with no simultaneous pop drops the data and sets OVF.
  - A simultaneous push and pop leaves occupancy unchanged.
- Mode behaviour:
  - IE = 0 (polled): IRQ is held at 1; software polls SR.NF before writing BR.
  - IE = 1 (interrupt): IRQ = 0 whenever NF = 1 or TERR = 1; otherwise IRQ = 1. IRQ is registered and updates one cycle after its cause.
- Printer FSM, with states IDLE, STROBE, WAIT_LO and WAIT_HI:
  - IDLE, when occupancy > 0 and RDY = 1:
    - PD <= FIFO head;
    - pop the FIFO;
    - TR <= 1;
    - load the strobe counter with STB_CYC-1;
    - go to STROBE.
  - STROBE: decrement the counter. When it reaches 0, set TR <= 0, clear the timeout counter and go to WAIT_LO.
  - WAIT_LO:
    - RDY = 0 moves to WAIT_HI.
    - Otherwise the timeout counter increments; at TMO_CYC the block sets TERR and returns to IDLE, and the byte counts as lost.
  - WAIT_HI: RDY = 1 moves to IDLE.
- PD holds the last transmitted byte until the next load.
- TERR does not stall the FIFO. The next byte is attempted normally.

## Timing
- Reset (RST = 1, asynchronous) sets: TR = 0, PD = 0, Dout = 0, IRQ = 1, IE = 0, OVF = 0, TERR = 0, FIFO empty, FSM in IDLE. While RST is asserted the block ignores the bus and RDY.
- Read latency: Dout is valid on the clock edge after RW = 2'b10 is sampled, and holds until the next read.
- Write latency: a write takes effect at the sampling edge. SR and LVL reflect it on a read issued on the next cycle.
- TR: rises on the edge that pops the FIFO, and is high for exactly STB_CYC cycles.
- Minimum per-byte period: 1 + STB_CYC + 1 + 1 cycles, i.e. load, strobe, the WAIT_LO edge that sees RDY = 0 and the WAIT_HI edge that sees RDY = 1.
- A back-to-back load may occur on the edge after WAIT_HI exits, provided RDY = 1.
- Simultaneous events:
  - Clearing a flag while the same flag is being set: set wins.
  - Pushing to BR while the FSM pops from a full FIFO: the push is accepted and OVF is unchanged.
- Reset mid-transfer aborts immediately: TR drops with no further edges, and FIFO contents are discarded.

## Test plan
- Reset and idle:
  - Assert RST mid-STROBE -> TR = 0, PD = 0, IRQ = 1 at once.
  - After release, SR read gives 0xC0 and LVL read gives 0.
- Polled single byte (IE = 0, STB_CYC = 2):
  - Write BR = 0xA5; the printer model drops RDY 1 cycle after TR rises and raises it 13 cycles later.
  - Required: PD = 0xA5, TR high exactly 2 cycles, IRQ stays 1 throughout, SR = 0xC0 afterwards.
- FIFO fill and overflow (DEPTH = 4, RDY held 0):
  - Write 5 bytes 0x01..0x05 -> LVL = 4, SR.NF = 0, OVF = 1.
  - Release RDY -> PD sequence 0x01..0x04 only.
- Interrupt mode:
  - Set IE = 1 with the FIFO empty -> IRQ = 0.
  - Fill to 4 entries -> IRQ = 1.
  - After the first pop -> IRQ = 0 one cycle later.
  - Write SR with IE = 0 -> IRQ = 1.
- Timeout (TMO_CYC = 64): keep RDY = 1 after TR -> TERR sets 64 cycles after TR falls, and the FSM loads the next byte. Writing 0x10 to SR clears TERR.
- Push during pop when full: with the FIFO full, write BR on the exact IDLE-pop edge -> push accepted, LVL stays 4, OVF stays 0.
